// File: rtl/video_control_signals.sv
// Shared definitions for the PPU video path: bit positions of the sequencer
// control word and the dot/line timing constants used to decode it.
package video_control_signals;

  localparam int CONTROL_W = 16;

  // One bit per event in the control word consumed by video_address.
  typedef enum logic [3:0] {
    video_fetch_nt_byte_addr   = 4'd0,
    video_fetch_nt_byte_data   = 4'd1,
    video_fetch_at_byte_addr   = 4'd2,
    video_fetch_at_byte_data   = 4'd3,
    video_fetch_tile_lo_addr   = 4'd4,
    video_fetch_tile_lo_data   = 4'd5,
    video_fetch_tile_hi_addr   = 4'd6,
    video_fetch_tile_hi_data   = 4'd7,
    video_incr_hori_v          = 4'd8,
    video_incr_vert_v          = 4'd9,
    video_hori_v_eq_t          = 4'd10,
    video_vert_v_eq_t          = 4'd11,
    video_shift_reload         = 4'd12,
    video_set_vblank           = 4'd13,
    video_clr_vblank           = 4'd14,
    video_control_spare        = 4'd15   // never driven; keeps the word 16 bits
  } video_control_e;

  // Default frame geometry (NTSC PPU).
  localparam int DOTS_PER_LINE   = 341;
  localparam int LINES_PER_FRAME = 262;
  localparam int VBLANK_LINE     = 241;

  // Background fetch windows within a fetch line.
  localparam logic [8:0] FETCH_A_FIRST   = 9'd1;
  localparam logic [8:0] FETCH_A_LAST    = 9'd256;
  localparam logic [8:0] FETCH_B_FIRST   = 9'd321;
  localparam logic [8:0] FETCH_B_LAST    = 9'd336;

  // Shifter reloads: every 8 dots from 9 to 257, plus the two prefetch tiles.
  localparam logic [8:0] RELOAD_FIRST    = 9'd9;
  localparam logic [8:0] RELOAD_LAST     = 9'd257;
  localparam logic [8:0] RELOAD_PRE0     = 9'd329;
  localparam logic [8:0] RELOAD_PRE1     = 9'd337;

  // Scroll register updates.
  localparam logic [8:0] INCR_VERT_DOT   = 9'd256;
  localparam logic [8:0] HORI_COPY_DOT   = 9'd257;
  localparam logic [8:0] VERT_COPY_FIRST = 9'd280;
  localparam logic [8:0] VERT_COPY_LAST  = 9'd304;

  // Dot on which the vblank flag is set or cleared.
  localparam logic [8:0] FLAG_DOT        = 9'd1;

endpackage

// File: rtl/video_timing_counter.sv
// Dot / line / frame-parity counters. Also exposes the next position so the
// control decode can be registered in step with the counters.
module video_timing_counter
  import video_control_signals::*;
#(
  parameter int P_dots_per_line   = DOTS_PER_LINE,
  parameter int P_lines_per_frame = LINES_PER_FRAME
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_render,
  output logic [8:0] o_dot,
  output logic [8:0] o_line,
  output logic       o_frame_odd,
  output logic [8:0] o_next_dot,
  output logic [8:0] o_next_line
);

  localparam logic [8:0] LP_LAST_DOT  = 9'(P_dots_per_line - 1);
  localparam logic [8:0] LP_SKIP_DOT  = 9'(P_dots_per_line - 2);
  localparam logic [8:0] LP_LAST_LINE = 9'(P_lines_per_frame - 1);

  logic [8:0] r_dot;
  logic [8:0] r_line;
  logic       r_frame_odd;
  logic [8:0] w_next_dot;
  logic [8:0] w_next_line;
  logic       w_next_odd;
  logic       w_skip;

  // Next position; odd rendered frames drop the last dot of the pre-render line.
  always_comb begin
    w_skip      = i_render && r_frame_odd && (r_line == LP_LAST_LINE) && (r_dot == LP_SKIP_DOT);
    w_next_dot  = r_dot + 9'd1;
    w_next_line = r_line;
    w_next_odd  = r_frame_odd;
    if (w_skip || (r_dot == LP_LAST_DOT)) begin
      w_next_dot = '0;
      if (r_line == LP_LAST_LINE) begin
        w_next_line = '0;
        w_next_odd  = ~r_frame_odd;
      end else begin
        w_next_line = r_line + 9'd1;
      end
    end
  end

  // Position and frame parity registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dot       <= '0;
      r_line      <= '0;
      r_frame_odd <= 1'b0;
    end else begin
      r_dot       <= w_next_dot;
      r_line      <= w_next_line;
      r_frame_odd <= w_next_odd;
    end
  end

  assign o_dot       = r_dot;
  assign o_line      = r_line;
  assign o_frame_odd = r_frame_odd;
  assign o_next_dot  = w_next_dot;
  assign o_next_line = w_next_line;

endmodule

// File: rtl/video_sequencer.sv
// PPU dot/scanline sequencer: drives the per-dot control word for the video
// address path and owns the vblank flag and NMI request.
module video_sequencer
  import video_control_signals::*;
#(
  parameter int P_dots_per_line   = DOTS_PER_LINE,
  parameter int P_lines_per_frame = LINES_PER_FRAME,
  parameter int P_vblank_line     = VBLANK_LINE
) (
  input  logic                 I_clock,
  input  logic                 I_reset,
  input  logic [7:0]           I_ppuctrl,
  input  logic [7:0]           I_ppumask,
  input  logic                 I_stat_rd,
  output logic [CONTROL_W-1:0] O_control,
  output logic [8:0]           O_dot,
  output logic [8:0]           O_line,
  output logic                 O_visible,
  output logic                 O_vblank,
  output logic                 O_nmi,
  output logic                 O_frame_odd
);

  // Rendering lines end where the post-render line begins, just before vblank.
  localparam logic [8:0] LP_POST_LINE   = 9'(P_vblank_line - 1);
  localparam logic [8:0] LP_VBLANK_LINE = 9'(P_vblank_line);
  localparam logic [8:0] LP_PRE_LINE    = 9'(P_lines_per_frame - 1);

  logic [8:0]           w_dot;
  logic [8:0]           w_line;
  logic                 w_frame_odd;
  logic [8:0]           w_next_dot;
  logic [8:0]           w_next_line;
  logic                 w_render;
  logic                 w_set_vblank;
  logic                 w_clr_vblank;
  logic                 w_vblank_next;
  logic                 w_unused_bits;
  logic [CONTROL_W-1:0] r_control;
  logic                 r_vblank;

  // Position -> control word. Emitted regardless of PPUMASK.
  function automatic logic [CONTROL_W-1:0] f_decode(input logic [8:0] d, input logic [8:0] l);
    logic [CONTROL_W-1:0] c;
    logic                 fline;
    logic                 fdot;
    c     = '0;
    fline = (l < LP_POST_LINE) || (l == LP_PRE_LINE);
    fdot  = ((d >= FETCH_A_FIRST) && (d <= FETCH_A_LAST)) ||
            ((d >= FETCH_B_FIRST) && (d <= FETCH_B_LAST));
    if (fline && fdot) begin
      case (d[2:0])
        3'd1:    c[video_fetch_nt_byte_addr] = 1'b1;
        3'd2:    c[video_fetch_nt_byte_data] = 1'b1;
        3'd3:    c[video_fetch_at_byte_addr] = 1'b1;
        3'd4:    c[video_fetch_at_byte_data] = 1'b1;
        3'd5:    c[video_fetch_tile_lo_addr] = 1'b1;
        3'd6:    c[video_fetch_tile_lo_data] = 1'b1;
        3'd7:    c[video_fetch_tile_hi_addr] = 1'b1;
        default: begin
          c[video_fetch_tile_hi_data] = 1'b1;
          // At dot 256 the vertical increment takes the place of the horizontal one.
          if (d != INCR_VERT_DOT) c[video_incr_hori_v] = 1'b1;
        end
      endcase
    end
    if (fline && (d == INCR_VERT_DOT)) c[video_incr_vert_v] = 1'b1;
    if (fline && (((d >= RELOAD_FIRST) && (d <= RELOAD_LAST) && (d[2:0] == 3'd1)) ||
                  (d == RELOAD_PRE0) || (d == RELOAD_PRE1)))
      c[video_shift_reload] = 1'b1;
    if (fline && (d == HORI_COPY_DOT)) c[video_hori_v_eq_t] = 1'b1;
    if ((l == LP_PRE_LINE) && (d >= VERT_COPY_FIRST) && (d <= VERT_COPY_LAST))
      c[video_vert_v_eq_t] = 1'b1;
    if ((l == LP_VBLANK_LINE) && (d == FLAG_DOT)) c[video_set_vblank] = 1'b1;
    if ((l == LP_PRE_LINE) && (d == FLAG_DOT)) c[video_clr_vblank] = 1'b1;
    return c;
  endfunction

  assign w_render      = |I_ppumask[4:3];
  assign w_unused_bits = ^{I_ppuctrl[6:0], I_ppumask[7:5], I_ppumask[2:0]};

  video_timing_counter #(
    .P_dots_per_line  (P_dots_per_line),
    .P_lines_per_frame(P_lines_per_frame)
  ) u_counter (
    .i_clock    (I_clock),
    .i_reset_n  (I_reset),
    .i_render   (w_render),
    .o_dot      (w_dot),
    .o_line     (w_line),
    .o_frame_odd(w_frame_odd),
    .o_next_dot (w_next_dot),
    .o_next_line(w_next_line)
  );

  // Vblank flag update; a status read on the setting edge wins, so a read one
  // dot early suppresses the whole frame's flag and NMI.
  always_comb begin
    w_set_vblank  = (w_next_line == LP_VBLANK_LINE) && (w_next_dot == FLAG_DOT);
    w_clr_vblank  = (w_next_line == LP_PRE_LINE) && (w_next_dot == FLAG_DOT);
    w_vblank_next = r_vblank;
    if (w_clr_vblank) w_vblank_next = 1'b0;
    if (w_set_vblank) w_vblank_next = 1'b1;
    if (I_stat_rd)    w_vblank_next = 1'b0;
  end

  // Control word and flag registered from the next position so they line up with O_dot/O_line.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_control <= '0;
      r_vblank  <= 1'b0;
    end else begin
      r_control <= f_decode(w_next_dot, w_next_line);
      r_vblank  <= w_vblank_next;
    end
  end

  assign O_control   = r_control;
  assign O_dot       = w_dot;
  assign O_line      = w_line;
  assign O_frame_odd = w_frame_odd;
  assign O_vblank    = r_vblank;
  assign O_nmi       = r_vblank & I_ppuctrl[7];
  assign O_visible   = (w_line < LP_POST_LINE) && (w_dot >= 9'd1) && (w_dot <= 9'd256);

endmodule
